// File: rtl/key_debounce_capture.sv
// Per-channel synchroniser, counter debounce, press/release pulses and sticky W1C capture for board KEY/SW pins.
// Optional long-press detection is built only when KEY_LONG_PRESS_EN is defined.
module key_debounce_capture #(
  parameter int WIDTH           = 4,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] capture,
  input  logic [WIDTH-1:0] capture_clr,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] long_held
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_param
    $error("key_debounce_capture: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] w_norm;
  logic [WIDTH-1:0] w_flip;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;

  logic [WIDTH-1:0] r_sync_p0;
  logic [WIDTH-1:0] r_sync_p1;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_level;
  logic [WIDTH-1:0] r_press;
  logic [WIDTH-1:0] r_release;
  logic [WIDTH-1:0] r_capture;

  // A channel flips on the edge its stable-mismatch count completes.
  always_comb begin
    w_norm = raw_in ^ ((ACTIVE_LOW != 0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}});
    w_flip = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_flip[i] = (r_sync_p1[i] != r_level[i]) && (r_cnt[i] == CNT_LAST);
    end
    w_rise = w_flip & r_sync_p1;
    w_fall = w_flip & ~r_sync_p1;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_sync_p0 <= '0;
      r_sync_p1 <= '0;
      r_level   <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_capture <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      // stage p0 -> p1: two-flop synchroniser
      r_sync_p0 <= w_norm;
      r_sync_p1 <= r_sync_p0;
      // stage p1 -> debounced level, pulses and capture
      r_level   <= r_level ^ w_flip;
      r_press   <= w_rise;
      r_release <= w_fall;
      r_capture <= r_press | (r_capture & ~capture_clr);
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync_p1[i] == r_level[i]) || w_flip[i]) begin
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign level_out     = r_level;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign capture       = r_capture;

`ifdef KEY_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1) + 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE = (LONG_CYCLES >= 2) ? HW'(LONG_CYCLES - 2) : '0;

  function automatic logic [HW-1:0] hold_sat_inc(input logic [HW-1:0] v);
    return (v == HOLD_MAX) ? v : v + 1'b1;
  endfunction

  logic [HW-1:0]    r_hold [WIDTH];
  logic [WIDTH-1:0] r_long_pulse;
  logic [WIDTH-1:0] r_long_held;
  logic [WIDTH-1:0] w_long_hit;

  // The hit marks the edge on which the hold counter becomes LONG_CYCLES-1.
  always_comb begin
    w_long_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (LONG_CYCLES == 1) begin
        w_long_hit[i] = w_rise[i];
      end else begin
        w_long_hit[i] = r_level[i] && (r_hold[i] == HOLD_PRE);
      end
    end
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_long_pulse <= '0;
      r_long_held  <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_hold[i] <= '0;
      end
    end else begin
      r_long_pulse <= w_long_hit;
      r_long_held  <= (r_long_held | w_long_hit) & ~w_fall;
      for (int i = 0; i < WIDTH; i++) begin
        r_hold[i] <= r_level[i] ? hold_sat_inc(r_hold[i]) : '0;
      end
    end
  end

  assign long_pulse = r_long_pulse;
  assign long_held  = r_long_held;
`else
  assign long_pulse = '0;
  assign long_held  = '0;
`endif

endmodule

// File: tb/tb_key_debounce_capture.sv
// Directed bench for key_debounce_capture: 4-bit active-low KEY instance (D=4) and 10-bit active-high SW instance.
module tb_key_debounce_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] raw = 4'hF;
  logic [3:0] clr = 4'h0;
  logic [3:0] lvl, pp, rp, cap, lp, lh;

  logic [9:0] raw10 = 10'h000;
  logic [9:0] clr10 = 10'h000;
  logic [9:0] lvl10, pp10, rp10, cap10, lp10, lh10;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_debounce_capture #(.WIDTH(4), .ACTIVE_LOW(1), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut (
    .clk_clk(clk), .reset_reset(rst), .raw_in(raw), .level_out(lvl), .press_pulse(pp),
    .release_pulse(rp), .capture(cap), .capture_clr(clr), .long_pulse(lp), .long_held(lh)
  );

  key_debounce_capture #(.WIDTH(10), .ACTIVE_LOW(0), .DEBOUNCE_CYCLES(4), .LONG_CYCLES(10)) dut10 (
    .clk_clk(clk), .reset_reset(rst), .raw_in(raw10), .level_out(lvl10), .press_pulse(pp10),
    .release_pulse(rp10), .capture(cap10), .capture_clr(clr10), .long_pulse(lp10), .long_held(lh10)
  );

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] lvl;
    logic [3:0] pp;
    logic [3:0] rp;
    logic [3:0] cap;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic [3:0] rw, input logic [3:0] c,
                     input logic [3:0] l, input logic [3:0] p, input logic [3:0] q, input logic [3:0] k);
    vec_t v;
    v.rst = r; v.raw = rw; v.clr = c; v.lvl = l; v.pp = p; v.rp = q; v.cap = k;
    repeat (n) tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst, raw, clr  ->  level, press, release, capture  (values after the edge)
    add(2, 1, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);  // reset
    add(5, 0, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);  // press bit0, edges 1..5
    add(1, 0, 4'hE, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0);  // edge 6
    add(2, 0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
    add(3, 0, 4'hC, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);  // 3-cycle glitch on bit1
    add(3, 0, 4'hE, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);
    add(5, 0, 4'hF, 4'h0, 4'h1, 4'h0, 4'h0, 4'h1);  // release bit0
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1);
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1);
    add(1, 0, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0);  // clear bit0
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0);  // clear with nothing pending
    add(5, 0, 4'hD, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);  // press bit1
    add(1, 0, 4'hD, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0);
    add(1, 0, 4'hD, 4'h2, 4'h2, 4'h0, 4'h0, 4'h2);  // clear during press pulse: set wins
    add(1, 0, 4'hD, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);
    add(5, 0, 4'h6, 4'h0, 4'h2, 4'h0, 4'h0, 4'h2);  // press 0,3 and release 1 together
    add(1, 0, 4'h6, 4'h0, 4'h9, 4'h9, 4'h2, 4'h2);
    add(1, 0, 4'h6, 4'h0, 4'h9, 4'h0, 4'h0, 4'hB);
    add(1, 0, 4'h6, 4'h4, 4'h9, 4'h0, 4'h0, 4'hB);  // clear on a non-pending bit
    add(5, 0, 4'hF, 4'h0, 4'h9, 4'h0, 4'h0, 4'hB);  // release 0,3
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h9, 4'hB);
    add(1, 0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB);
    add(5, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'hB);  // press bit2, 3 counted cycles
    add(2, 1, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);  // reset mid-count, button held
    add(5, 0, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'hB, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0);
    add(1, 0, 4'hB, 4'h0, 4'h4, 4'h0, 4'h0, 4'h4);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst;
      raw = tbl[i].raw;
      clr = tbl[i].clr;
      tick();
      check("level_out", i, 32'(lvl), 32'(tbl[i].lvl));
      check("press_pulse", i, 32'(pp), 32'(tbl[i].pp));
      check("release_pulse", i, 32'(rp), 32'(tbl[i].rp));
      check("capture", i, 32'(cap), 32'(tbl[i].cap));
`ifndef KEY_LONG_PRESS_EN
      check("long_pulse", i, 32'(lp), 32'h0);
      check("long_held", i, 32'(lh), 32'h0);
`endif
    end
    clr = 4'h0;

    // Active-high 10-channel instance
    raw10 = 10'h201;
    repeat (5) tick();
    check("sw_level_early", 0, 32'(lvl10), 32'h0);
    tick();
    check("sw_level", 1, 32'(lvl10), 32'h201);
    check("sw_press", 2, 32'(pp10), 32'h201);
    tick();
    check("sw_capture", 3, 32'(cap10), 32'h201);

`ifdef KEY_LONG_PRESS_EN
    rst = 1'b1; raw = 4'hF;
    repeat (2) tick();
    rst = 1'b0;
    raw = 4'hE;
    repeat (6) tick();
    check("lp_level", 0, 32'(lvl), 32'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("lp_pulse", k, 32'(lp), (k == 9) ? 32'h1 : 32'h0);
      check("lp_held", k, 32'(lh), (k >= 9) ? 32'h1 : 32'h0);
    end
    raw = 4'hF;
    repeat (5) tick();
    check("lp_held_pre_release", 0, 32'(lh), 32'h1);
    tick();
    check("lp_release", 1, 32'(rp), 32'h1);
    check("lp_held_cleared", 2, 32'(lh), 32'h0);
    raw = 4'hE;
    repeat (5) tick();
    raw = 4'hF;
    for (int k = 0; k < 12; k++) begin
      tick();
      check("short_no_pulse", k, 32'(lp), 32'h0);
      check("short_no_held", k, 32'(lh), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
